uart_rx: RTL and testbench

Serial receiver that sits directly downstream of the transmit stage on the UART link. It consumes the asynchronous `tx` line driven by the far-end transmitter and recovers 8N1 frames: one start bit (0), eight data bits LSB first, one stop bit (1). Each completed frame is presented as a byte with a one-cycle strobe, and framing errors are flagged. It uses the same `CLK_FREQ`/`BAUD_RATE` parameterisation as the transmitter, so both ends agree on bit timing.

---
 rtl/uart_rx.sv | 134 +++++++++++++
 tb/tb_uart_rx.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM, registered
// byte/strobe outputs with framing-error detection and break handling.
module uart_rx #(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned BIT_PERIOD  = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_PERIOD = BIT_PERIOD / 2;
  localparam logic [13:0] BitLast     = 14'(BIT_PERIOD - 1);
  localparam logic [13:0] HalfLast    = 14'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} state_e;

  state_e      state_q, state_d;
  logic        rx_meta_q, rx_s_q;
  logic [13:0] timer_q, timer_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        frame_err_q, frame_err_d;
  logic        busy_q, busy_d;
  // Stop-bit verdict, held one cycle before it reaches the output strobes.
  logic        done_q, done_d;
  logic        err_pend_q, err_pend_d;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q + 14'd1;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    done_d     = 1'b0;
    err_pend_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (!rx_s_q) state_d = StStart;
      end
      StStart: begin
        if (timer_q == HalfLast) begin
          timer_d = '0;
          if (!rx_s_q) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (timer_q == BitLast) begin
          timer_d   = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (timer_q == BitLast) begin
          timer_d = '0;
          if (rx_s_q) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            err_pend_d = 1'b1;
            state_d    = StWaitHigh;
          end
        end
      end
      StWaitHigh: begin
        timer_d = '0;
        if (rx_s_q) state_d = StIdle;
      end
      default: begin
        timer_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Shift register is not touched until the next DATA state, so it is safe to
  // load data_out from it one cycle after the stop-bit decision.
  always_comb begin
    data_d      = done_q ? shift_q : data_q;
    valid_d     = done_q;
    frame_err_d = err_pend_q;
    busy_d      = (state_q != StIdle) || done_q || err_pend_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= StIdle;
      timer_q     <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_pend_q  <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_pend_q  <= err_pend_d;
    end
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected bytes/errors,
// an independent monitor pops and checks them whenever a strobe appears.
module tb_uart_rx;

  localparam int unsigned CLK_FREQ  = 1600;
  localparam int unsigned BAUD_RATE = 100;
  localparam int          BIT       = 16;
  localparam int          LATENCY   = 155;  // 3 + HALF + 9*BIT

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .data_out (data_out),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    bit         err;
    bit         chk_t;
    int         at;
  } exp_t;

  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] last_good = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: consumes expectations only when the DUT strobes.
  initial begin
    int   last_v;
    exp_t e;
    last_v = -10;
    forever begin
      @(negedge clk);
      if (cyc == last_v + 1) check("busy_fall_after_valid", {31'd0, busy}, 32'd0);
      if (valid || frame_err) begin
        check("valid_err_exclusive", {31'd0, valid && frame_err}, 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_strobe", {30'd0, valid, frame_err}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("strobe_kind", {31'd0, frame_err}, {31'd0, e.err});
          check("data_out", {24'd0, data_out}, {24'd0, e.data});
          if (e.chk_t) check("latency", cyc, e.at);
          if (valid) begin
            check("busy_at_valid", {31'd0, busy}, 32'd1);
            last_v = cyc;
          end
        end
      end
    end
  end

  // Called at #1 after a posedge; returns at #1 after the last edge of the stop bit.
  task automatic send(input logic [7:0] d, input int bitlen, input bit stop, input bit chk);
    exp_t       e;
    logic [9:0] bits;
    bits    = {stop, d, 1'b0};
    e.data  = stop ? d : last_good;
    e.err   = !stop;
    e.chk_t = chk;
    e.at    = cyc + 1 + LATENCY;
    sb.push_back(e);
    if (stop) last_good = d;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (bitlen) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] bits;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", {24'd0, data_out}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    idle(5);

    // Single frame with exact latency
    send(8'hA5, BIT, 1'b1, 1'b1);
    idle(20);

    // Back-to-back frames, no idle gap
    send(8'h00, BIT, 1'b1, 1'b1);
    send(8'hFF, BIT, 1'b1, 1'b1);
    send(8'h3C, BIT, 1'b1, 1'b1);
    idle(20);

    // Start-bit glitch
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(30);
    check("glitch_data_kept", {24'd0, data_out}, {24'd0, last_good});
    check("glitch_busy_idle", {31'd0, busy}, 32'd0);

    // Framing error followed by a break
    send(8'h55, BIT, 1'b0, 1'b1);
    repeat (100) @(posedge clk);
    #1;
    check("break_busy", {31'd0, busy}, 32'd1);
    idle(20);
    check("after_break_data", {24'd0, data_out}, {24'd0, last_good});
    check("after_break_busy", {31'd0, busy}, 32'd0);

    // Reset during data bit 4 of 0x81
    bits = {1'b1, 8'h81, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rx = bits[i];
      repeat (BIT) @(posedge clk);
      #1;
    end
    rx = bits[5];
    repeat (BIT / 2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_data_out", {24'd0, data_out}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_valid", {31'd0, valid}, 32'd0);
    check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    rx = 1'b1;
    last_good = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    idle(10);
    send(8'h81, BIT, 1'b1, 1'b1);
    idle(20);

    // Baud skew
    send(8'hC3, BIT + 1, 1'b1, 1'b0);
    idle(30);
    send(8'hC3, BIT - 1, 1'b1, 1'b0);
    idle(30);
    check("final_data_out", {24'd0, data_out}, 32'hC3);

    for (int i = 0; i < 500 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
